// File: rtl/mux_nto1_pipe.sv
// N-to-1 select with a registered valid/ready output stage and a one-entry skid buffer.
// Out-of-range selects yield zero data and set a sticky error flag.
module mux_nto1_pipe #(
    parameter int WIDTH  = 5,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err
);

    logic [WIDTH-1:0] cap_data;
    logic             cap_oor;
    logic [WIDTH-1:0] skid_data;
    logic [SEL_W-1:0] skid_sel;
    logic             skid_valid;

    logic accept;
    logic prim_free;
    logic prim_load_new;
    logic prim_load_skid;
    logic skid_load;
    logic prim_v_nxt;
    logic skid_v_nxt;

    // Compare-based decode: a select with no matching input falls through to zero.
    always_comb begin
        cap_data = '0;
        cap_oor  = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                cap_data = in_bus[k*WIDTH +: WIDTH];
                cap_oor  = 1'b0;
            end
        end
    end

    always_comb begin
        accept         = in_valid && in_ready;
        prim_free      = !out_valid || out_ready;
        prim_load_new  = 1'b0;
        prim_load_skid = 1'b0;
        skid_load      = 1'b0;
        prim_v_nxt     = out_valid;
        skid_v_nxt     = skid_valid;
        if (prim_free) begin
            if (skid_valid) begin
                prim_load_skid = 1'b1;
                prim_v_nxt     = 1'b1;
                skid_load      = accept;
                skid_v_nxt     = accept;
            end else begin
                prim_load_new  = accept;
                prim_v_nxt     = accept;
                skid_v_nxt     = 1'b0;
            end
        end else begin
            skid_load  = accept;
            skid_v_nxt = skid_valid || accept;
        end
        if (flush) begin
            prim_v_nxt = 1'b0;
            skid_v_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data   <= '0;
            out_sel    <= '0;
            out_valid  <= 1'b0;
            skid_data  <= '0;
            skid_sel   <= '0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
            sel_err    <= 1'b0;
        end else begin
            out_valid  <= prim_v_nxt;
            skid_valid <= skid_v_nxt;
            in_ready   <= !skid_v_nxt;
            if (prim_load_skid) begin
                out_data <= skid_data;
                out_sel  <= skid_sel;
            end else if (prim_load_new) begin
                out_data <= cap_data;
                out_sel  <= sel;
            end
            if (skid_load) begin
                skid_data <= cap_data;
                skid_sel  <= sel;
            end
            if (accept && cap_oor)
                sel_err <= 1'b1;
        end
    end

endmodule
